// File: rtl/branch_pkg.sv
// Shared definitions for the 6502 relative-branch unit: opcodes, status flag
// positions, FSM state encoding and the captured request payload.
package branch_pkg;

    // Relative-branch opcodes
    localparam logic [7:0] OP_BPL = 8'h10;
    localparam logic [7:0] OP_BMI = 8'h30;
    localparam logic [7:0] OP_BVC = 8'h50;
    localparam logic [7:0] OP_BVS = 8'h70;
    localparam logic [7:0] OP_BRA = 8'h80;
    localparam logic [7:0] OP_BCC = 8'h90;
    localparam logic [7:0] OP_BCS = 8'hB0;
    localparam logic [7:0] OP_BNE = 8'hD0;
    localparam logic [7:0] OP_BEQ = 8'hF0;

    // Bit positions inside the P register
    localparam int unsigned FLAG_N = 7;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        ADD,
        FIXUP,
        DONE
    } branch_state_t;

    // Width-independent part of a request, captured at accept
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] offset;
        logic [7:0] status;
    } branch_req_t;

endpackage

// File: rtl/branch_unit_if.sv
// Request/result handshake bundle between decode and the branch unit.
//   master : decode/PC side - drives the request and done_ready
//   slave  : branch_unit    - drives req_ready and the done_* result
interface branch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_opcode;
    logic [7:0]        req_offset;
    logic [ADDR_W-1:0] req_pc;
    logic [7:0]        req_status;

    logic              done_valid;
    logic              done_ready;
    logic              done_taken;
    logic              done_page_cross;
    logic              done_illegal;
    logic [ADDR_W-1:0] done_pc;

    modport master (
        output req_valid, req_opcode, req_offset, req_pc, req_status, done_ready,
        input  req_ready, done_valid, done_taken, done_page_cross, done_illegal, done_pc
    );

    modport slave (
        input  req_valid, req_opcode, req_offset, req_pc, req_status, done_ready,
        output req_ready, done_valid, done_taken, done_page_cross, done_illegal, done_pc
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode.
//   opcode    : branch opcode
//   status    : captured P register
//   cond_c    : branch is taken
//   illegal_c : opcode is not a (supported) relative branch
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int unsigned ENABLE_BRA = 0
) (
    input  logic [7:0] opcode,
    input  logic [7:0] status,
    output logic       cond_c,
    output logic       illegal_c
);

    always_comb begin
        cond_c    = 1'b0;
        illegal_c = 1'b0;
        case (opcode)
            OP_BPL: cond_c = ~status[FLAG_N];
            OP_BMI: cond_c =  status[FLAG_N];
            OP_BVC: cond_c = ~status[FLAG_V];
            OP_BVS: cond_c =  status[FLAG_V];
            OP_BCC: cond_c = ~status[FLAG_C];
            OP_BCS: cond_c =  status[FLAG_C];
            OP_BNE: cond_c = ~status[FLAG_Z];
            OP_BEQ: cond_c =  status[FLAG_Z];
            OP_BRA: begin
                if (ENABLE_BRA != 0) cond_c    = 1'b1;
                else                 illegal_c = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Sequential relative-branch execution unit with 6502 cycle timing
// (2 cycles not taken, 3 taken, 4 taken across a page).
//   clk, rst        : clock, synchronous active-high reset
//   flush           : abort the in-flight request / drop a same-cycle request
//   bus (slave)     : request in, next-PC result out, valid/ready on both sides
//   cnt_taken       : saturating count of retired taken branches
//   cnt_not_taken   : saturating count of retired not-taken (incl. illegal)
//   cnt_page_cross  : saturating count of retired taken page-crossing branches
module branch_unit
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned PAGE_BITS  = 8,
    parameter int unsigned INSTR_LEN  = 2,
    parameter int unsigned ENABLE_BRA = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    branch_unit_if.slave     bus,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_not_taken,
    output logic [CNT_W-1:0] cnt_page_cross
);

    localparam int unsigned SEXT_W = ADDR_W - 8;

    branch_state_t     state, state_nx;
    branch_req_t       req_q;
    logic [ADDR_W-1:0] pc_q;

    logic              rr_q, rr_nx;
    logic              dv_q, dv_nx;
    logic              tk_q, tk_nx;
    logic              cx_q, cx_nx;
    logic              il_q, il_nx;
    logic [ADDR_W-1:0] npc_q, npc_nx;

    logic              cond_c, illegal_c;
    logic [ADDR_W-1:0] fall_c, sext_c, tgt_c;
    logic              page_diff_c;
    logic              accept_c, retire_c;

    branch_cond_eval #(
        .ENABLE_BRA (ENABLE_BRA)
    ) u_cond (
        .opcode    (req_q.opcode),
        .status    (req_q.status),
        .cond_c    (cond_c),
        .illegal_c (illegal_c)
    );

    // Target arithmetic from the captured request; all sums wrap modulo 2**ADDR_W
    assign fall_c      = pc_q + ADDR_W'(INSTR_LEN);
    assign sext_c      = {{SEXT_W{req_q.offset[7]}}, req_q.offset};
    assign tgt_c       = fall_c + sext_c;
    assign page_diff_c = (tgt_c[ADDR_W-1:PAGE_BITS] != fall_c[ADDR_W-1:PAGE_BITS]);

    // flush wins over both the accept and the done handshake
    assign accept_c = (state == IDLE) && bus.req_valid && !flush;
    assign retire_c = (state == DONE) && bus.done_ready && !flush;

    assign bus.req_ready       = rr_q;
    assign bus.done_valid      = dv_q;
    assign bus.done_taken      = tk_q;
    assign bus.done_page_cross = cx_q;
    assign bus.done_illegal    = il_q;
    assign bus.done_pc         = npc_q;

    // Next state and next registered outputs; outputs hold unless a transition sets them
    always_comb begin
        state_nx = state;
        dv_nx    = dv_q;
        tk_nx    = tk_q;
        cx_nx    = cx_q;
        il_nx    = il_q;
        npc_nx   = npc_q;

        case (state)
            IDLE: begin
                if (bus.req_valid) state_nx = EVAL;
            end
            EVAL: begin
                if (illegal_c || !cond_c) begin
                    state_nx = DONE;
                    dv_nx    = 1'b1;
                    tk_nx    = 1'b0;
                    cx_nx    = 1'b0;
                    il_nx    = illegal_c;
                    npc_nx   = fall_c;
                end else begin
                    state_nx = ADD;
                end
            end
            ADD: begin
                if (page_diff_c) begin
                    state_nx = FIXUP;
                end else begin
                    state_nx = DONE;
                    dv_nx    = 1'b1;
                    tk_nx    = 1'b1;
                    cx_nx    = 1'b0;
                    il_nx    = 1'b0;
                    npc_nx   = tgt_c;
                end
            end
            FIXUP: begin
                state_nx = DONE;
                dv_nx    = 1'b1;
                tk_nx    = 1'b1;
                cx_nx    = 1'b1;
                il_nx    = 1'b0;
                npc_nx   = tgt_c;
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_nx = IDLE;
                    dv_nx    = 1'b0;
                    tk_nx    = 1'b0;
                    cx_nx    = 1'b0;
                    il_nx    = 1'b0;
                    npc_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (flush) begin
            state_nx = IDLE;
            dv_nx    = 1'b0;
            tk_nx    = 1'b0;
            cx_nx    = 1'b0;
            il_nx    = 1'b0;
            npc_nx   = '0;
        end

        rr_nx = (state_nx == IDLE);
    end

    // State, outputs, captured request and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_q           <= 1'b1;
            dv_q           <= 1'b0;
            tk_q           <= 1'b0;
            cx_q           <= 1'b0;
            il_q           <= 1'b0;
            npc_q          <= '0;
            req_q          <= '0;
            pc_q           <= '0;
            cnt_taken      <= '0;
            cnt_not_taken  <= '0;
            cnt_page_cross <= '0;
        end else begin
            state <= state_nx;
            rr_q  <= rr_nx;
            dv_q  <= dv_nx;
            tk_q  <= tk_nx;
            cx_q  <= cx_nx;
            il_q  <= il_nx;
            npc_q <= npc_nx;

            if (accept_c) begin
                req_q.opcode <= bus.req_opcode;
                req_q.offset <= bus.req_offset;
                req_q.status <= bus.req_status;
                pc_q         <= bus.req_pc;
            end

            // Saturating statistics, updated once per retired result
            if (retire_c) begin
                if (tk_q) begin
                    if (cnt_taken != '1) cnt_taken <= cnt_taken + CNT_W'(1);
                end else begin
                    if (cnt_not_taken != '1) cnt_not_taken <= cnt_not_taken + CNT_W'(1);
                end
                if (cx_q && (cnt_page_cross != '1)) begin
                    cnt_page_cross <= cnt_page_cross + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a default instance (BRA illegal, 16-bit
// counters) and one with BRA enabled and 2-bit counters for saturation.
module tb_branch_unit;

    logic clk = 1'b0;
    logic rst;
    logic flush0, flush1;

    always #5 clk = ~clk;

    branch_unit_if #(.ADDR_W(16)) if0 ();
    branch_unit_if #(.ADDR_W(16)) if1 ();

    logic [15:0] ct0, cn0, cp0;
    logic [1:0]  ct1, cn1, cp1;

    branch_unit #(
        .ADDR_W(16), .PAGE_BITS(8), .INSTR_LEN(2), .ENABLE_BRA(0), .CNT_W(16)
    ) u0 (
        .clk(clk), .rst(rst), .flush(flush0), .bus(if0),
        .cnt_taken(ct0), .cnt_not_taken(cn0), .cnt_page_cross(cp0)
    );

    branch_unit #(
        .ADDR_W(16), .PAGE_BITS(8), .INSTR_LEN(2), .ENABLE_BRA(1), .CNT_W(2)
    ) u1 (
        .clk(clk), .rst(rst), .flush(flush1), .bus(if1),
        .cnt_taken(ct1), .cnt_not_taken(cn1), .cnt_page_cross(cp1)
    );

    int sel;
    logic        m_rr, m_dv, m_tk, m_cx, m_il;
    logic [15:0] m_pc, m_ct, m_cn, m_cp;

    // View of the currently selected instance
    always_comb begin
        if (sel == 0) begin
            m_rr = if0.req_ready;  m_dv = if0.done_valid; m_tk = if0.done_taken;
            m_cx = if0.done_page_cross; m_il = if0.done_illegal; m_pc = if0.done_pc;
            m_ct = ct0; m_cn = cn0; m_cp = cp0;
        end else begin
            m_rr = if1.req_ready;  m_dv = if1.done_valid; m_tk = if1.done_taken;
            m_cx = if1.done_page_cross; m_il = if1.done_illegal; m_pc = if1.done_pc;
            m_ct = 16'(ct1); m_cn = 16'(cn1); m_cp = 16'(cp1);
        end
    end

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  off;
        logic [7:0]  st;
        logic [15:0] pc;
        logic        tk;
        logic        cx;
        logic        il;
        logic [15:0] npc;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    int total = 0;
    int bad   = 0;
    int e_tk, e_nt, e_cx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] off,
                         input logic [7:0] st, input logic [15:0] pc,
                         input logic dr, input logic fl);
        if (sel == 0) begin
            if0.req_valid = v; if0.req_opcode = op; if0.req_offset = off;
            if0.req_status = st; if0.req_pc = pc; if0.done_ready = dr; flush0 = fl;
        end else begin
            if1.req_valid = v; if1.req_opcode = op; if1.req_offset = off;
            if1.req_status = st; if1.req_pc = pc; if1.done_ready = dr; flush1 = fl;
        end
    endtask

    // Accept one request, scramble the request inputs, count edges to done_valid
    task automatic issue(input logic [7:0] op, input logic [7:0] off, input logic [7:0] st,
                         input logic [15:0] pc, input logic dr, output int lat);
        drive(1'b1, op, off, st, pc, dr, 1'b0);
        tick();
        drive(1'b0, ~op, ~off, ~st, ~pc, dr, 1'b0);
        lat = 0;
        while (!m_dv && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    int lat;

    initial begin
        sel = 0;
        flush0 = 1'b0; flush1 = 1'b0;
        rst = 1'b1;
        sel = 1; drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        sel = 0; drive(1'b1, 8'hD0, 8'h10, 8'h00, 16'h1000, 1'b1, 1'b0);

        //            op     off    st     pc        tk    cx    il    npc      lat
        vecs[0]  = '{8'hD0, 8'h10, 8'h00, 16'h1000, 1'b1, 1'b0, 1'b0, 16'h1012, 2};
        vecs[1]  = '{8'hF0, 8'h10, 8'h00, 16'h1000, 1'b0, 1'b0, 1'b0, 16'h1002, 1};
        vecs[2]  = '{8'hB0, 8'h20, 8'h01, 16'h10F0, 1'b1, 1'b1, 1'b0, 16'h1112, 3};
        vecs[3]  = '{8'h80, 8'h10, 8'hFF, 16'h3000, 1'b0, 1'b0, 1'b1, 16'h3002, 1};
        vecs[4]  = '{8'h10, 8'hF0, 8'h00, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h1226, 2};
        vecs[5]  = '{8'h70, 8'h00, 8'h40, 16'h20FE, 1'b1, 1'b0, 1'b0, 16'h2100, 2};
        vecs[6]  = '{8'h50, 8'h10, 8'h40, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h4002, 1};
        vecs[7]  = '{8'h90, 8'h80, 8'h00, 16'h5080, 1'b1, 1'b0, 1'b0, 16'h5002, 2};
        vecs[8]  = '{8'h30, 8'h10, 8'h00, 16'h6000, 1'b0, 1'b0, 1'b0, 16'h6002, 1};
        vecs[9]  = '{8'h00, 8'h10, 8'hFF, 16'h7000, 1'b0, 1'b0, 1'b1, 16'h7002, 1};
        vecs[10] = '{8'hF0, 8'h05, 8'h02, 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0005, 2};
        vecs[11] = '{8'hD0, 8'h7F, 8'h00, 16'h1000, 1'b1, 1'b0, 1'b0, 16'h1081, 2};

        // Reset dominates a pending request
        tick(); tick();
        check("reset_req_ready", 32'(m_rr), 32'd1);
        check("reset_done_valid", 32'(m_dv), 32'd0);
        check("reset_done_pc", 32'(m_pc), 32'd0);
        check("reset_flags", {29'd0, m_tk, m_cx, m_il}, 32'd0);
        check("reset_counters", 32'(m_ct) + 32'(m_cn) + 32'(m_cp), 32'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        tick();

        e_tk = 0; e_nt = 0; e_cx = 0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("v%0d_req_ready", i), 32'(m_rr), 32'd1);
            issue(vecs[i].op, vecs[i].off, vecs[i].st, vecs[i].pc, 1'b1, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_done_valid", i), 32'(m_dv), 32'd1);
            check($sformatf("v%0d_taken", i), 32'(m_tk), 32'(vecs[i].tk));
            check($sformatf("v%0d_cross", i), 32'(m_cx), 32'(vecs[i].cx));
            check($sformatf("v%0d_illegal", i), 32'(m_il), 32'(vecs[i].il));
            check($sformatf("v%0d_done_pc", i), 32'(m_pc), 32'(vecs[i].npc));
            tick();
            if (vecs[i].tk) e_tk++; else e_nt++;
            if (vecs[i].cx) e_cx++;
            check($sformatf("v%0d_valid_drop", i), 32'(m_dv), 32'd0);
            check($sformatf("v%0d_cnt_taken", i), 32'(m_ct), 32'(e_tk));
            check($sformatf("v%0d_cnt_not_taken", i), 32'(m_cn), 32'(e_nt));
            check($sformatf("v%0d_cnt_cross", i), 32'(m_cp), 32'(e_cx));
        end

        // BMI wrapping below 0x0000 and backpressure on the result
        issue(8'h30, 8'h80, 8'h80, 16'h0000, 1'b0, lat);
        check("wrap_latency", 32'(lat), 32'd3);
        check("wrap_done_pc", 32'(m_pc), 32'hFF82);
        check("wrap_cross", 32'(m_cx), 32'd1);
        check("wrap_taken", 32'(m_tk), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_valid", i), 32'(m_dv), 32'd1);
            check($sformatf("hold%0d_pc", i), 32'(m_pc), 32'hFF82);
            check($sformatf("hold%0d_flags", i), {29'd0, m_tk, m_cx, m_il}, 32'd6);
            check($sformatf("hold%0d_req_ready", i), 32'(m_rr), 32'd0);
            check($sformatf("hold%0d_cnt_taken", i), 32'(m_ct), 32'(e_tk));
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        tick();
        e_tk++; e_cx++;
        check("hold_release_valid", 32'(m_dv), 32'd0);
        check("hold_release_cnt_taken", 32'(m_ct), 32'(e_tk));
        check("hold_release_cnt_cross", 32'(m_cp), 32'(e_cx));

        // flush while in FIXUP
        drive(1'b1, 8'hB0, 8'h20, 8'h01, 16'h10F0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        tick(); tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_fix%0d_valid", i), 32'(m_dv), 32'd0);
            check($sformatf("flush_fix%0d_req_ready", i), 32'(m_rr), 32'd1);
            tick();
        end
        check("flush_fix_counters", {m_ct, m_cp}, {16'(e_tk), 16'(e_cx)});

        // flush in IDLE discards a simultaneous request
        drive(1'b1, 8'hD0, 8'h10, 8'h00, 16'h1000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("flush_idle%0d_req_ready", i), 32'(m_rr), 32'd1);
            check($sformatf("flush_idle%0d_valid", i), 32'(m_dv), 32'd0);
            tick();
        end

        // flush beats a same-cycle done handshake
        drive(1'b1, 8'hF0, 8'h10, 8'h00, 16'h1000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
        tick();
        check("flush_done_valid_before", 32'(m_dv), 32'd1);
        check("flush_done_pc_before", 32'(m_pc), 32'h1002);
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        check("flush_done_valid_after", 32'(m_dv), 32'd0);
        check("flush_done_pc_after", 32'(m_pc), 32'd0);
        check("flush_done_cnt_not_taken", 32'(m_cn), 32'(e_nt));

        // rst during ADD
        drive(1'b1, 8'hD0, 8'h10, 8'h00, 16'h1000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_add%0d_valid", i), 32'(m_dv), 32'd0);
            check($sformatf("rst_add%0d_req_ready", i), 32'(m_rr), 32'd1);
            tick();
        end
        check("rst_add_counters", 32'(m_ct) + 32'(m_cn) + 32'(m_cp), 32'd0);

        // BRA with ENABLE_BRA=1, then counter saturation at 2 bits
        sel = 1;
        #1;
        issue(8'h80, 8'hFE, 8'h00, 16'h2000, 1'b1, lat);
        check("bra_latency", 32'(lat), 32'd2);
        check("bra_done_pc", 32'(m_pc), 32'h2000);
        check("bra_flags", {29'd0, m_tk, m_cx, m_il}, 32'd4);
        tick();
        check("sat1_cnt_taken", 32'(m_ct), 32'd1);
        for (int n = 2; n <= 5; n++) begin
            issue(8'h80, 8'h04, 8'h00, 16'h3000, 1'b1, lat);
            check($sformatf("sat%0d_done_pc", n), 32'(m_pc), 32'h3006);
            tick();
            check($sformatf("sat%0d_cnt_taken", n), 32'(m_ct), (n > 3) ? 32'd3 : 32'(n));
        end
        check("sat_cnt_not_taken", 32'(m_cn), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
